id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 190 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Purpose  : ID/EX pipeline register for a 5-stage MIPS-style core.
//             Captures decoded instruction fields and the ALU control code,
//             detects load-use hazards against the instruction held in EX,
//             inserts bubbles on flush/stall/invalid slots, and forwards
//             EX/MEM and MEM/WB results onto the ALU operands.
//  Ports    : clk, rst (async, active-high)
//             id_*            decode-stage instruction fields (in)
//             flush           squash the instruction entering EX (in)
//             exmem_*/memwb_* forwarding sources (in)
//             stall_id        load-use stall to PC and IF/ID (out, comb)
//             ex_a, ex_b      ALU operands after forwarding (out)
//             ex_ctl, ex_shamt, ex_store_data, ex_wr_reg, ex_ctrl,
//             ex_valid        EX-stage instruction fields (out)
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic [5:0]  id_funct,
    input  logic [1:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic [3:0]  id_ctrl,
    input  logic        flush,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic        stall_id,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [2:0]  ex_ctl,
    output logic [4:0]  ex_shamt,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_wr_reg,
    output logic [3:0]  ex_ctrl,
    output logic        ex_valid
);

    // ALU control encodings
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SLL = 3'b011;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    // Bit position of mem_read inside the {reg_write, mem_read, mem_write, mem_to_reg} bundle
    localparam int c_MEM_READ_BIT = 2;

    logic [2:0]  w_alu_ctl;
    logic        w_stall;
    logic        w_bubble;

    logic        r_valid;
    logic [3:0]  r_ctrl;
    logic [4:0]  r_wr_reg;
    logic [2:0]  r_ctl;
    logic [4:0]  r_shamt;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic        r_alu_src;

    logic [31:0] w_fwd_rs;
    logic [31:0] w_fwd_rt;

    // ------------------------------------------------------------------
    // ALU control decode from alu_op / funct
    // ------------------------------------------------------------------
    always_comb begin
        w_alu_ctl = c_ALU_ADD;
        case (id_alu_op)
            2'b00: w_alu_ctl = c_ALU_ADD;
            2'b01: w_alu_ctl = c_ALU_SUB;
            2'b11: w_alu_ctl = c_ALU_OR;
            2'b10: begin
                case (id_funct)
                    6'b100000: w_alu_ctl = c_ALU_ADD;
                    6'b100010: w_alu_ctl = c_ALU_SUB;
                    6'b100100: w_alu_ctl = c_ALU_AND;
                    6'b100101: w_alu_ctl = c_ALU_OR;
                    6'b101010: w_alu_ctl = c_ALU_SLT;
                    6'b000000: w_alu_ctl = c_ALU_SLL;
                    default:   w_alu_ctl = c_ALU_ADD;
                endcase
            end
            default: w_alu_ctl = c_ALU_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Load-use hazard: a load in EX whose destination is read by ID.
    // r_valid is cleared asynchronously, so this is 0 while rst is high.
    // ------------------------------------------------------------------
    always_comb begin
        w_stall = r_valid & r_ctrl[c_MEM_READ_BIT] & (r_wr_reg != 5'd0) & id_valid &
                  ((r_wr_reg == id_rs) | (r_wr_reg == id_rt));
    end

    // Flush, stall and an empty decode slot all collapse into one bubble.
    assign w_bubble = flush | w_stall | ~id_valid;
    assign stall_id = w_stall;

    // ------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctrl    <= 4'd0;
            r_wr_reg  <= 5'd0;
            r_ctl     <= 3'd0;
            r_shamt   <= 5'd0;
            r_rs      <= 5'd0;
            r_rt      <= 5'd0;
            r_rs_data <= 32'd0;
            r_rt_data <= 32'd0;
            r_imm     <= 32'd0;
            r_alu_src <= 1'b0;
        end else begin
            // Data fields load unconditionally; only the control that can
            // change architectural state is zeroed for a bubble.
            r_ctl     <= w_alu_ctl;
            r_shamt   <= id_shamt;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_rs_data <= id_rs_data;
            r_rt_data <= id_rt_data;
            r_imm     <= id_imm;
            r_alu_src <= id_alu_src;
            if (w_bubble) begin
                r_valid  <= 1'b0;
                r_ctrl   <= 4'd0;
                r_wr_reg <= 5'd0;
            end else begin
                r_valid  <= 1'b1;
                r_ctrl   <= id_ctrl;
                r_wr_reg <= id_reg_dst ? id_rd : id_rt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Forwarding muxes, combinational after the register so that the
    // current-cycle EX/MEM and MEM/WB values are used. EX/MEM is newer
    // and therefore wins; register 0 never matches.
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_rs = r_rs_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rs))
            w_fwd_rs = exmem_result;
        else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rs))
            w_fwd_rs = memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rt))
            w_fwd_rt = exmem_result;
        else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rt))
            w_fwd_rt = memwb_result;
    end

    assign ex_a          = w_fwd_rs;
    assign ex_b          = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data = w_fwd_rt;
    assign ex_ctl        = r_ctl;
    assign ex_shamt      = r_shamt;
    assign ex_wr_reg     = r_wr_reg;
    assign ex_ctrl       = r_ctrl;
    assign ex_valid      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Purpose  : Directed self-checking testbench for id_ex_stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_imm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src;
    logic        id_reg_dst;
    logic [3:0]  id_ctrl;
    logic        flush;
    logic        exmem_reg_write;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        stall_id;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [2:0]  ex_ctl;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wr_reg;
    logic [3:0]  ex_ctrl;
    logic        ex_valid;

    int checks = 0;
    int errors = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_funct(id_funct), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
        .id_reg_dst(id_reg_dst), .id_ctrl(id_ctrl), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall_id(stall_id), .ex_a(ex_a), .ex_b(ex_b), .ex_ctl(ex_ctl),
        .ex_shamt(ex_shamt), .ex_store_data(ex_store_data), .ex_wr_reg(ex_wr_reg),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                             input logic [31:0] imm, input logic [4:0] sh, input logic [5:0] fn,
                             input logic [1:0] op, input logic asrc, input logic rdst,
                             input logic [3:0] ctrl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
        id_imm = imm; id_shamt = sh; id_funct = fn; id_alu_op = op; id_alu_src = asrc;
        id_reg_dst = rdst; id_ctrl = ctrl;
    endtask

    task automatic clear_fwd();
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; clear_fwd();
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'h77, 5'd1, 6'h20, 2'b10, 1'b0, 1'b1, 4'b1000);
        step(); step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
        checks++; if (ex_ctrl !== 4'd0) begin errors++; $display("FAIL reset_ctrl got %b exp 0000", ex_ctrl); end
        checks++; if (ex_a !== 32'd0 || ex_b !== 32'd0) begin errors++; $display("FAIL reset_ab got %h/%h exp 0/0", ex_a, ex_b); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall_id); end
        rst = 1'b0;
    endtask

    task automatic test_rtype_sub();
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'h0000000A, 32'h00000003, 32'h0, 5'd0, 6'b100010, 2'b10, 1'b0, 1'b1, 4'b1000);
        step();
        checks++; if (ex_ctl !== 3'b110) begin errors++; $display("FAIL sub_ctl got %b exp 110", ex_ctl); end
        checks++; if (ex_a !== 32'h0A) begin errors++; $display("FAIL sub_a got %h exp 0000000a", ex_a); end
        checks++; if (ex_b !== 32'h03) begin errors++; $display("FAIL sub_b got %h exp 00000003", ex_b); end
        checks++; if (ex_wr_reg !== 5'd3) begin errors++; $display("FAIL sub_wr_reg got %0d exp 3", ex_wr_reg); end
        checks++; if (ex_valid !== 1'b1 || ex_ctrl !== 4'b1000) begin errors++; $display("FAIL sub_valid_ctrl got %b/%b exp 1/1000", ex_valid, ex_ctrl); end
    endtask

    task automatic test_alu_decode();
        logic [1:0] ops  [7] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [5:0] fns  [7] = '{6'b100010, 6'b100000, 6'b000000, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        logic [2:0] exps [7] = '{3'b010, 3'b110, 3'b001, 3'b000, 3'b001, 3'b111, 3'b010};
        for (int i = 0; i < 7; i++) begin
            // I-type style: write register rt, operand B from immediate
            set_instr(1'b1, 5'd4, 5'd9, 5'd12, 32'h100, 32'h200, 32'hFFFF_FFF0, 5'd0, fns[i], ops[i], 1'b1, 1'b0, 4'b1000);
            step();
            checks++; if (ex_ctl !== exps[i]) begin errors++; $display("FAIL alu_decode_%0d got %b exp %b", i, ex_ctl, exps[i]); end
        end
        checks++; if (ex_wr_reg !== 5'd9) begin errors++; $display("FAIL reg_dst_rt got %0d exp 9", ex_wr_reg); end
        checks++; if (ex_b !== 32'hFFFF_FFF0) begin errors++; $display("FAIL alu_src_imm got %h exp fffffff0", ex_b); end
        checks++; if (ex_store_data !== 32'h200) begin errors++; $display("FAIL store_data got %h exp 00000200", ex_store_data); end
    endtask

    task automatic test_load_use();
        // lw r5, 0(r1)
        set_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h1000, 32'h0, 32'h0, 5'd0, 6'h0, 2'b00, 1'b1, 1'b0, 4'b1101);
        step();
        // add r7, r5, r6
        set_instr(1'b1, 5'd5, 5'd6, 5'd7, 32'h1, 32'h2, 32'h0, 5'd0, 6'b100000, 2'b10, 1'b0, 1'b1, 4'b1000);
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL load_use_stall got %b exp 1", stall_id); end
        step();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 4'd0 || ex_wr_reg !== 5'd0) begin
            errors++; $display("FAIL load_use_bubble got v=%b c=%b w=%0d exp 0/0000/0", ex_valid, ex_ctrl, ex_wr_reg); end
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL load_use_release got %b exp 0", stall_id); end
        step();
        checks++; if (ex_valid !== 1'b1 || ex_wr_reg !== 5'd7 || ex_ctrl !== 4'b1000) begin
            errors++; $display("FAIL load_use_resume got v=%b w=%0d c=%b exp 1/7/1000", ex_valid, ex_wr_reg, ex_ctrl); end
        // lw r0 followed by a reader of r0: no hazard
        set_instr(1'b1, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 6'h0, 2'b00, 1'b1, 1'b0, 4'b1101);
        step();
        set_instr(1'b1, 5'd0, 5'd0, 5'd8, 32'h0, 32'h0, 32'h0, 5'd0, 6'b100000, 2'b10, 1'b0, 1'b1, 4'b1000);
        #1;
        checks++; if (stall_id !== 1'b0) begin errors++; $display("FAIL load_r0_no_stall got %b exp 0", stall_id); end
        step();
    endtask

    task automatic test_forwarding();
        set_instr(1'b1, 5'd7, 5'd8, 5'd9, 32'h33, 32'h44, 32'h55, 5'd0, 6'b100000, 2'b10, 1'b0, 1'b1, 4'b1000);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd7; exmem_result = 32'h11;
        memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_result = 32'h22;
        #1;
        checks++; if (ex_a !== 32'h11) begin errors++; $display("FAIL fwd_exmem_prio got %h exp 00000011", ex_a); end
        exmem_reg_write = 1'b0;
        #1;
        checks++; if (ex_a !== 32'h22) begin errors++; $display("FAIL fwd_memwb got %h exp 00000022", ex_a); end
        memwb_reg_write = 1'b0;
        #1;
        checks++; if (ex_a !== 32'h33) begin errors++; $display("FAIL fwd_none got %h exp 00000033", ex_a); end
        memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'h99;
        #1;
        checks++; if (ex_b !== 32'h99 || ex_store_data !== 32'h99) begin
            errors++; $display("FAIL fwd_rt got %h/%h exp 00000099/00000099", ex_b, ex_store_data); end
        clear_fwd();
        // rs = r0 with EX/MEM claiming r0: must not forward
        set_instr(1'b1, 5'd0, 5'd2, 5'd3, 32'h0, 32'h5, 32'h0, 5'd0, 6'b100000, 2'b10, 1'b0, 1'b1, 4'b1000);
        step();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hFF;
        #1;
        checks++; if (ex_a !== 32'h0) begin errors++; $display("FAIL fwd_r0 got %h exp 00000000", ex_a); end
        clear_fwd();
    endtask

    task automatic test_sll_flush_stall();
        set_instr(1'b1, 5'd0, 5'd2, 5'd3, 32'h0, 32'h1, 32'h0, 5'd4, 6'b000000, 2'b10, 1'b0, 1'b1, 4'b1000);
        step();
        checks++; if (ex_ctl !== 3'b011 || ex_shamt !== 5'd4) begin
            errors++; $display("FAIL sll got ctl=%b sh=%0d exp 011/4", ex_ctl, ex_shamt); end
        // lw r5 in EX, then dependent instruction plus flush in the same cycle
        set_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 6'h0, 2'b00, 1'b1, 1'b0, 4'b1101);
        step();
        set_instr(1'b1, 5'd5, 5'd6, 5'd7, 32'h0, 32'h0, 32'h0, 5'd0, 6'b100000, 2'b10, 1'b0, 1'b1, 4'b1000);
        flush = 1'b1;
        #1;
        checks++; if (stall_id !== 1'b1) begin errors++; $display("FAIL flush_stall_stall got %b exp 1", stall_id); end
        step();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 4'd0) begin
            errors++; $display("FAIL flush_stall_bubble got %b/%b exp 0/0000", ex_valid, ex_ctrl); end
        set_instr(1'b1, 5'd1, 5'd2, 5'd10, 32'h0, 32'h0, 32'h0, 5'd0, 6'b100000, 2'b10, 1'b0, 1'b1, 4'b1000);
        step();
        checks++; if (ex_valid !== 1'b1 || ex_wr_reg !== 5'd10) begin
            errors++; $display("FAIL flush_stall_single got %b/%0d exp 1/10", ex_valid, ex_wr_reg); end
        // empty decode slot
        set_instr(1'b0, 5'd1, 5'd2, 5'd11, 32'h0, 32'h0, 32'h0, 5'd0, 6'b100000, 2'b10, 1'b0, 1'b1, 4'b1000);
        step();
        checks++; if (ex_valid !== 1'b0 || ex_ctrl !== 4'd0 || ex_wr_reg !== 5'd0) begin
            errors++; $display("FAIL id_invalid_bubble got %b/%b/%0d exp 0/0000/0", ex_valid, ex_ctrl, ex_wr_reg); end
    endtask

    task automatic test_async_reset();
        set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'hAB, 32'hCD, 32'hEF, 5'd7, 6'b100010, 2'b10, 1'b0, 1'b1, 4'b1001);
        step();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got %b exp 1", ex_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({ex_valid, ex_ctrl, ex_ctl, ex_wr_reg, ex_shamt, stall_id} !== 19'd0 ||
                      ex_a !== 32'd0 || ex_b !== 32'd0 || ex_store_data !== 32'd0) begin
            errors++; $display("FAIL areset_clear got v=%b c=%b ctl=%b w=%0d sh=%0d a=%h b=%h sd=%h exp all 0",
                               ex_valid, ex_ctrl, ex_ctl, ex_wr_reg, ex_shamt, ex_a, ex_b, ex_store_data); end
        #1 rst = 1'b0;
        step();
        checks++; if (ex_valid !== 1'b1 || ex_ctrl !== 4'b1001 || ex_a !== 32'hAB) begin
            errors++; $display("FAIL areset_resume got %b/%b/%h exp 1/1001/000000ab", ex_valid, ex_ctrl, ex_a); end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_alu_decode();
        test_load_use();
        test_forwarding();
        test_sll_flush_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
